// File: rtl/bus_pkg.sv
// Shared bus constants and packet field helpers, used by the per-driver FIFO,
// the arbiter bench and the scoreboard.
package bus_pkg;

  localparam int unsigned PCKG_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 2;
  localparam logic [7:0]  BROD_ID   = 8'd16;

  // Destination ID sits in the top byte of a packet.
  function automatic logic [7:0] pkt_dest(input logic [PCKG_DEF-1:0] pkt);
    return pkt[PCKG_DEF-1 -: 8];
  endfunction

  function automatic logic [PCKG_DEF-9:0] pkt_payload(input logic [PCKG_DEF-1:0] pkt);
    return pkt[PCKG_DEF-9:0];
  endfunction

endpackage

// File: rtl/bus_driver_fifo.sv
// Per-driver transmit FIFO: first-word fall-through head for the bus arbiter,
// plus sticky overflow/underflow flags and a saturating drop counter.
module bus_driver_fifo
  import bus_pkg::*;
#(
  parameter int unsigned PCKG  = PCKG_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [PCKG-1:0]          wr_data,
  output logic                     full,
  input  logic                     pop,
  output logic [PCKG-1:0]          D_pop,
  output logic                     pndng,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf,
  output logic [CNTW-1:0]          drops,
  input  logic                     clr_status
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]   FullCnt = CW'(DEPTH);
  localparam logic [CNTW-1:0] DropMax = '1;

  logic [PCKG-1:0] mem_q [DEPTH];
  logic [AW-1:0]   rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [CNTW-1:0] drops_q, drops_d;

  logic accept, drop, valid_pop, empty_pop;

  // Decodes come from the count register only, never from inputs.
  always_comb begin
    full      = (cnt_q == FullCnt);
    pndng     = (cnt_q != '0);
    valid_pop = pop && pndng;
    empty_pop = pop && !pndng;
    accept    = wr_en && (!full || pop);
    drop      = wr_en && full && !pop;
  end

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (accept)    wp_d = wp_q + AW'(1);
    if (valid_pop) rp_d = rp_q + AW'(1);
    if (accept && !valid_pop)      cnt_d = cnt_q + CW'(1);
    else if (valid_pop && !accept) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is intentionally not reset; the empty mux hides stale contents.
  always_ff @(posedge clk) begin
    if (reset && accept) mem_q[wp_q] <= wr_data;
  end

  // A clear and a same-cycle event: the event wins on top of the cleared value.
  always_comb begin
    ovf_d   = clr_status ? 1'b0 : ovf_q;
    unf_d   = clr_status ? 1'b0 : unf_q;
    drops_d = clr_status ? '0 : drops_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_d != DropMax) drops_d = drops_d + CNTW'(1);
    end
    if (empty_pop) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      drops_q <= drops_d;
    end
  end

  assign D_pop = pndng ? mem_q[rp_q] : '0;
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign drops = drops_q;

endmodule

// File: tb/tb_bus_driver_fifo.sv
// Directed bench for bus_driver_fifo: driver pushes expected words into a queue,
// a negedge monitor compares every consumed head word against it.
module tb_bus_driver_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        pop;
  logic [15:0] D_pop;
  logic        pndng;
  logic [1:0]  count;
  logic        ovf;
  logic        unf;
  logic [7:0]  drops;
  logic        clr_status;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  bus_driver_fifo #(.PCKG(16), .DEPTH(2), .CNTW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .pop        (pop),
    .D_pop      (D_pop),
    .pndng      (pndng),
    .count      (count),
    .ovf        (ovf),
    .unf        (unf),
    .drops      (drops),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a pop consumed at the next edge must match the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b1 && pop === 1'b1 && pndng === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %h, expected none", D_pop);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (D_pop !== e) begin
          fails++;
          $display("FAIL pop_data: got %h, expected %h", D_pop, e);
        end
      end
    end
  end

  // One clock: drive inputs, take the edge, return to idle 1 ns later.
  task automatic cyc(input logic w, input logic [15:0] d, input logic p, input logic c);
    wr_en      = w;
    wr_data    = d;
    pop        = p;
    clr_status = c;
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    wr_data    = '0;
    pop        = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_pndng"}, 32'(pndng), 32'd0);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_dpop"},  32'(D_pop), 32'd0);
    check({tag, "_ovf"},   32'(ovf),   32'd0);
    check({tag, "_unf"},   32'(unf),   32'd0);
    check({tag, "_drops"}, 32'(drops), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check_reset_state("rst");
    reset = 1'b1;

    // Fill
    cyc(1'b1, 16'h1001, 1'b0, 1'b0); exp_q.push_back(16'h1001);
    check("wr1_pndng", 32'(pndng), 32'd1);
    check("wr1_dpop", 32'(D_pop), 32'h1001);
    cyc(1'b1, 16'h1002, 1'b0, 1'b0); exp_q.push_back(16'h1002);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd2);
    check("fill_dpop", 32'(D_pop), 32'h1001);

    // Overflow and saturation
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_drops", 32'(drops), 32'd1);
    check("ovf_count", 32'(count), 32'd2);
    check("ovf_dpop", 32'(D_pop), 32'h1001);
    for (int i = 0; i < 255; i++) cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("drops_sat", 32'(drops), 32'd255);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_drops", 32'(drops), 32'd0);

    // Simultaneous push/pop when full
    cyc(1'b1, 16'hC00C, 1'b1, 1'b0); exp_q.push_back(16'hC00C);
    check("pp_count", 32'(count), 32'd2);
    check("pp_dpop", 32'(D_pop), 32'h1002);
    check("pp_ovf", 32'(ovf), 32'd0);

    // Drain
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("drain1_dpop", 32'(D_pop), 32'hC00C);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("drain_pndng", 32'(pndng), 32'd0);
    check("drain_dpop", 32'(D_pop), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Empty pop with write
    cyc(1'b1, 16'h0105, 1'b1, 1'b0); exp_q.push_back(16'h0105);
    check("unf_flag", 32'(unf), 32'd1);
    check("unf_count", 32'(count), 32'd1);
    check("unf_dpop", 32'(D_pop), 32'h0105);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("unf_drain", 32'(count), 32'd0);

    // Wrap-around: write then pop, ten times
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0); exp_q.push_back(16'h2000 + 16'(i));
      check("wrap_wcount", 32'(count), 32'd1);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      check("wrap_pcount", 32'(count), 32'd0);
    end

    // Reset mid-operation with a pending write
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    check("mid_count", 32'(count), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    cyc(1'b1, 16'h3333, 1'b0, 1'b0);
    check_reset_state("midrst");
    reset = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("midrst_lost", 32'(pndng), 32'd0);

    // Clear coinciding with a drop
    cyc(1'b1, 16'h4001, 1'b0, 1'b0); exp_q.push_back(16'h4001);
    cyc(1'b1, 16'h4002, 1'b0, 1'b0); exp_q.push_back(16'h4002);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hBAD0, 1'b0, 1'b0);
    check("pre_clr_drops", 32'(drops), 32'd3);
    cyc(1'b1, 16'hBAD1, 1'b0, 1'b1);
    check("clrdrop_drops", 32'(drops), 32'd1);
    check("clrdrop_ovf", 32'(ovf), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("final_pndng", 32'(pndng), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
